brot_pixel_scheduler: RTL and testbench

//  Frame sequencer for the Mandelbrot accelerator. On cfg_start it rasters a WIDTHxHEIGHT

---
 rtl/brot_pkg.sv | 20 ++
 rtl/brot_rr_arbiter.sv | 45 ++++
 rtl/brot_pixel_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_brot_pixel_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/brot_pkg.sv
// Shared types and default widths for the Mandelbrot frame scheduler and its arbiters.
package brot_pkg;

    localparam int COORD_W_DEF = 32;
    localparam int DIM_W_DEF   = 12;
    localparam int ITER_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Index width for selecting one of n items; never narrower than one bit.
    function automatic int idx_w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/brot_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer,
// pointer moves just past the granted requester when the grant is consumed.
module brot_rr_arbiter
    import brot_pkg::*;
#(
    parameter int N = 4
)(
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = idx_w_of(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;
    int            j;

    always_comb begin
        grant = '0;
        gidx  = ptr;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                gidx     = PW'(j);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
        end
    end

endmodule

// File: rtl/brot_pixel_scheduler.sv
// Frame sequencer: rasters a frame, dispatches pixel coordinates to the iteration cores
// and merges their results into a single completion-ordered output stream.
module brot_pixel_scheduler
    import brot_pkg::*;
#(
    parameter  int NUM_CORES = 4,
    parameter  int COORD_W   = COORD_W_DEF,
    parameter  int DIM_W     = DIM_W_DEF,
    parameter  int ITER_W    = ITER_W_DEF,
    localparam int IDX_W     = 2 * DIM_W
)(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cfg_start,
    input  logic signed [COORD_W-1:0]   cfg_re0,
    input  logic signed [COORD_W-1:0]   cfg_im0,
    input  logic signed [COORD_W-1:0]   cfg_step,
    input  logic [DIM_W-1:0]            cfg_width,
    input  logic [DIM_W-1:0]            cfg_height,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_CORES-1:0]        job_valid,
    input  logic [NUM_CORES-1:0]        job_ready,
    output logic signed [COORD_W-1:0]   job_re,
    output logic signed [COORD_W-1:0]   job_im,
    input  logic [NUM_CORES-1:0]        res_valid,
    output logic [NUM_CORES-1:0]        res_ready,
    input  logic [NUM_CORES*ITER_W-1:0] res_iter,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ITER_W-1:0]           out_iter,
    output logic [IDX_W-1:0]            out_index
);

    localparam int KW = idx_w_of(NUM_CORES);

    sched_state_t state, state_nx;

    logic signed [COORD_W-1:0] re0_reg, step_reg;
    logic signed [COORD_W-1:0] re_acc, im_acc;
    logic [DIM_W-1:0]          width_reg, height_reg;
    logic [DIM_W-1:0]          x_cnt, y_cnt;
    logic [IDX_W-1:0]          pix_idx;
    logic [IDX_W-1:0]          idx_reg [NUM_CORES];
    logic [NUM_CORES-1:0]      pending;
    logic [NUM_CORES-1:0]      disp_req, coll_req;
    logic [KW-1:0]             disp_k, coll_k;
    logic                      disp_fire, coll_fire;
    logic                      start_ok, start_empty, last_pix, out_free;

    // Coordinates wrap modulo 2^COORD_W; no saturation anywhere on the raster walk.
    function automatic logic signed [COORD_W-1:0] coord_add(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b
    );
        return a + b;
    endfunction

    function automatic logic signed [COORD_W-1:0] coord_sub(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b
    );
        return a - b;
    endfunction

    assign start_ok    = (state == IDLE) && cfg_start;
    assign start_empty = (cfg_width == '0) || (cfg_height == '0);
    assign last_pix    = (x_cnt == width_reg - DIM_W'(1)) && (y_cnt == height_reg - DIM_W'(1));
    assign disp_req    = (state == RUN) ? job_ready : '0;
    assign out_free    = !out_valid || out_ready;
    assign coll_req    = out_free ? (res_valid & pending) : '0;
    assign disp_fire   = |job_valid;
    assign coll_fire   = |res_ready;
    assign job_re      = re_acc;
    assign job_im      = im_acc;

    brot_rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (disp_req),
        .advance (disp_fire),
        .grant   (job_valid)
    );

    brot_rr_arbiter #(.N(NUM_CORES)) u_coll_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (coll_req),
        .advance (coll_fire),
        .grant   (res_ready)
    );

    always_comb begin
        disp_k = '0;
        coll_k = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (job_valid[k]) disp_k = KW'(k);
            if (res_ready[k]) coll_k = KW'(k);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) state_nx = start_empty ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (disp_fire && last_pix) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pending == '0 && !out_valid) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (start_ok) begin
            re0_reg    <= cfg_re0;
            step_reg   <= cfg_step;
            width_reg  <= cfg_width;
            height_reg <= cfg_height;
        end
    end

    // Raster walk: advances by one pixel per accepted job.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            pix_idx <= '0;
            re_acc  <= '0;
            im_acc  <= '0;
        end else if (start_ok) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            pix_idx <= '0;
            re_acc  <= cfg_re0;
            im_acc  <= cfg_im0;
        end else if (disp_fire) begin
            pix_idx <= pix_idx + IDX_W'(1);
            if (x_cnt == width_reg - DIM_W'(1)) begin
                x_cnt  <= '0;
                y_cnt  <= y_cnt + DIM_W'(1);
                re_acc <= re0_reg;
                im_acc <= coord_sub(im_acc, step_reg);
            end else begin
                x_cnt  <= x_cnt + DIM_W'(1);
                re_acc <= coord_add(re_acc, step_reg);
            end
        end
    end

    // A core collected and re-dispatched in the same cycle stays pending with the new index.
    always_ff @(posedge clock) begin
        if (reset) pending <= '0;
        else       pending <= (pending & ~res_ready) | job_valid;
    end

    always_ff @(posedge clock) begin
        if (disp_fire) idx_reg[disp_k] <= pix_idx;
    end

    // Output register stage: one result per cycle, held until downstream accepts.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_iter  <= '0;
            out_index <= '0;
        end else if (coll_fire) begin
            out_valid <= 1'b1;
            out_iter  <= res_iter[int'(coll_k)*ITER_W +: ITER_W];
            out_index <= idx_reg[coll_k];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_brot_pixel_scheduler.sv
// Bench for brot_pixel_scheduler: behavioural core models plus a completion-order scoreboard.
module tb_brot_pixel_scheduler;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int DW = 12;
    localparam int IW = 16;
    localparam int XW = 2 * DW;

    logic            clock = 1'b0;
    logic            reset;
    logic            cfg_start;
    logic [CW-1:0]   cfg_re0, cfg_im0, cfg_step;
    logic [DW-1:0]   cfg_width, cfg_height;
    logic            busy, done;
    logic [N-1:0]    job_valid, job_ready;
    logic [CW-1:0]   job_re, job_im;
    logic [N-1:0]    res_valid, res_ready;
    logic [N*IW-1:0] res_iter;
    logic            out_valid, out_ready;
    logic [IW-1:0]   out_iter;
    logic [XW-1:0]   out_index;

    always #5 clock = ~clock;

    brot_pixel_scheduler #(.NUM_CORES(N), .COORD_W(CW), .DIM_W(DW), .ITER_W(IW)) dut (
        .clock(clock), .reset(reset), .cfg_start(cfg_start),
        .cfg_re0(cfg_re0), .cfg_im0(cfg_im0), .cfg_step(cfg_step),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .busy(busy), .done(done),
        .job_valid(job_valid), .job_ready(job_ready), .job_re(job_re), .job_im(job_im),
        .res_valid(res_valid), .res_ready(res_ready), .res_iter(res_iter),
        .out_valid(out_valid), .out_ready(out_ready), .out_iter(out_iter), .out_index(out_index)
    );

    // Core model: one job at a time; a core can take a new job in the cycle its result is taken.
    logic [N-1:0]  core_busy, core_en;
    int            core_wait [N];
    logic [XW-1:0] core_idx  [N];
    logic [IW-1:0] core_iter [N];
    assign job_ready = core_en & (~core_busy | (res_valid & res_ready));

    typedef struct packed { logic [XW-1:0] idx; logic [IW-1:0] iter; } res_t;
    res_t expq[$];
    int   coll_log[$];

    int      checks = 0, errors = 0;
    int      W, H, disp_cnt, out_cnt, coll_cnt, since_hs, done_cnt, same2_cnt;
    int      lat_fixed, ordy_mode;
    longint  idx_sum;
    bit      echo, rand_en, check_rr, busy_seen, busy_now, done_now;
    logic [31:0] re0m, im0m, stepm;
    logic [31:0] re_tab [4];
    logic [31:0] im_tab [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_re(input int n);
        logic [31:0] xx;
        if (W == 0) return 32'h0;
        xx = 32'(n % W);
        return re0m + xx * stepm;
    endfunction

    function automatic logic [31:0] exp_im(input int n);
        logic [31:0] yy;
        if (W == 0) return 32'h0;
        yy = 32'(n / W);
        return im0m - yy * stepm;
    endfunction

    task automatic drive_cores();
        for (int k = 0; k < N; k++) begin
            res_valid[k]          = core_busy[k] && (core_wait[k] == 0);
            res_iter[k*IW +: IW]  = core_iter[k];
        end
    endtask

    task automatic step();
        logic [N-1:0] jv, rr, rv, jr;
        bit   ov, ordy;
        int   dk;
        res_t r;
        @(negedge clock);
        jv = job_valid; rr = res_ready; rv = res_valid; jr = job_ready;
        ov = out_valid; ordy = out_ready;
        busy_now = busy; done_now = done;
        busy_seen |= busy;
        if (done) done_cnt++;
        since_hs++;
        chk("job_onehot", $countones(jv) <= 1, 1);
        chk("job_ready_respected", jv & ~jr, 0);
        chk("res_onehot", $countones(rr) <= 1, 1);
        chk("res_ready_pending_only", rr & ~(rv & core_busy), 0);
        if (ov && !ordy) chk("stall_no_collect", rr, 0);
        if (ov) begin
            if (expq.size() == 0) chk("out_unexpected_valid", ov, 0);
            else begin
                chk("out_index", out_index, expq[0].idx);
                chk("out_iter", out_iter, expq[0].iter);
            end
        end
        if (ov && ordy && expq.size() > 0) begin
            r = expq.pop_front();
            idx_sum += longint'(r.idx);
            out_cnt++;
            since_hs = 0;
        end
        for (int k = 0; k < N; k++) begin
            if (rr[k] && rv[k]) begin
                r.idx = core_idx[k]; r.iter = core_iter[k];
                expq.push_back(r);
                coll_cnt++;
                coll_log.push_back(k);
            end
        end
        if (rr[2] && rv[2] && jv[2]) same2_cnt++;
        dk = -1;
        for (int k = 0; k < N; k++) if (jv[k]) dk = k;
        if (dk >= 0) begin
            chk("disp_in_frame", disp_cnt < W * H, 1);
            chk("job_re", job_re, exp_re(disp_cnt));
            chk("job_im", job_im, exp_im(disp_cnt));
            if (echo && W == 4) begin
                chk("echo_re", job_re, re_tab[disp_cnt % 4]);
                chk("echo_im", job_im, im_tab[(disp_cnt / 4) % 2]);
            end
            if (check_rr) chk("grant_rr", dk, disp_cnt % N);
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < N; k++) begin
            if (rr[k] && rv[k]) core_busy[k] = 1'b0;
            else if (core_busy[k] && core_wait[k] > 0) core_wait[k]--;
        end
        if (dk >= 0) begin
            core_busy[dk] = 1'b1;
            core_idx[dk]  = XW'(disp_cnt);
            core_iter[dk] = echo ? IW'(disp_cnt % W) : IW'($urandom);
            core_wait[dk] = (lat_fixed >= 0) ? lat_fixed : int'($urandom % 4);
            disp_cnt++;
        end
        cfg_start = 1'b0;
        if (rand_en) core_en = N'($urandom);
        out_ready = (ordy_mode == 2) ? (($urandom % 4) != 0) : (ordy_mode == 1);
        drive_cores();
    endtask

    task automatic do_reset();
        reset = 1'b1; cfg_start = 1'b0; core_busy = '0; core_en = '0;
        for (int k = 0; k < N; k++) begin core_wait[k] = 0; core_iter[k] = '0; end
        expq.delete();
        W = 0; H = 0;
        out_ready = 1'b1;
        drive_cores();
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_job_valid", job_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_iter", out_iter, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_job_re", job_re, 0);
        chk("rst_job_im", job_im, 0);
        @(posedge clock); #1;
    endtask

    task automatic start_frame(input int w, input int h, input logic [31:0] r0,
                               input logic [31:0] i0, input logic [31:0] st);
        W = w; H = h; re0m = r0; im0m = i0; stepm = st;
        cfg_width = DW'(w); cfg_height = DW'(h);
        cfg_re0 = r0; cfg_im0 = i0; cfg_step = st;
        disp_cnt = 0; out_cnt = 0; idx_sum = 0; busy_seen = 0; since_hs = 0;
        cfg_start = 1'b1;
        step();
    endtask

    task automatic finish_frame(input int budget);
        bit got;
        int n;
        got = 0;
        n = W * H;
        for (int c = 0; c < budget && !got; c++) begin
            step();
            if (c == 0 && n > 0) chk("busy_in_run", busy_now, 1);
            if (done_now) got = 1;
        end
        chk("done_seen", got, 1);
        if (!got) begin
            do_reset();
            return;
        end
        chk("out_count", out_cnt, n);
        chk("disp_count", disp_cnt, n);
        chk("queue_empty", expq.size(), 0);
        chk("idx_sum", idx_sum, longint'(n) * longint'(n - 1) / 2);
        chk("busy_at_done", busy_now, 0);
        if (n > 0) chk("done_latency", (since_hs >= 1 && since_hs <= 2), 1);
        else       chk("busy_never_empty", busy_seen, 0);
        step();
        chk("done_one_cycle", done_now, 0);
    endtask

    initial begin
        int dc0;
        bit distinct;
        re_tab = '{32'hE000_0000, 32'hE800_0000, 32'hF000_0000, 32'hF800_0000};
        im_tab = '{32'h1000_0000, 32'h0800_0000};
        cfg_start = 0; cfg_re0 = 0; cfg_im0 = 0; cfg_step = 0; cfg_width = 0; cfg_height = 0;
        res_valid = '0; res_iter = '0; out_ready = 1'b1;
        done_cnt = 0; same2_cnt = 0; coll_cnt = 0;
        lat_fixed = 0; ordy_mode = 1; echo = 0; rand_en = 0; check_rr = 0;
        do_reset();

        // 4x2 echo frame: cores return x, fixed 3-cycle latency, all cores enabled
        core_en = '1; lat_fixed = 3; echo = 1; check_rr = 1; ordy_mode = 1;
        start_frame(4, 2, 32'hE000_0000, 32'h1000_0000, 32'h0800_0000);
        finish_frame(100);
        chk("same_cycle_core2", same2_cnt > 0, 1);
        check_rr = 0; echo = 0;

        // degenerate frames
        start_frame(0, 5, 32'h1, 32'h2, 32'h3);
        finish_frame(10);
        start_frame(3, 0, 32'h1, 32'h2, 32'h3);
        finish_frame(10);

        // output back-pressure for 20 cycles
        lat_fixed = 0; core_en = '1; ordy_mode = 0; out_ready = 1'b0;
        start_frame(4, 4, $urandom, $urandom, $urandom);
        coll_cnt = 0;
        repeat (20) step();
        chk("stall_single_collect", coll_cnt, 1);
        chk("stall_out_valid", out_valid, 1);
        ordy_mode = 1;
        coll_log.delete();
        for (int c = 0; c < 20 && coll_log.size() < 4; c++) step();
        distinct = (coll_log.size() >= 4);
        if (distinct)
            for (int a = 0; a < 4; a++)
                for (int b = a + 1; b < 4; b++)
                    if (coll_log[a] == coll_log[b]) distinct = 0;
        chk("release_rr_distinct", distinct, 1);
        finish_frame(400);

        // reset in the middle of a frame
        rand_en = 1; lat_fixed = -1; ordy_mode = 2;
        start_frame(4, 4, $urandom, $urandom, $urandom);
        for (int c = 0; c < 200 && disp_cnt < 3; c++) step();
        chk("reached_pixel3", disp_cnt >= 3, 1);
        dc0 = done_cnt;
        do_reset();
        repeat (5) step();
        chk("no_done_after_reset", done_cnt, dc0);
        start_frame(4, 4, $urandom, $urandom, $urandom);
        finish_frame(2000);

        // randomized frames
        for (int f = 0; f < 4; f++) begin
            start_frame(1 + int'($urandom % 6), 1 + int'($urandom % 4), $urandom, $urandom, $urandom);
            finish_frame(2000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
